lms_da_filter: RTL

LMS_DA_FILTER -- requirements
Module: lms_da_filter

---
 rtl/lms_da_filter_pkg.sv | 33 +++
 rtl/lms_da_mac.sv | 42 ++++
 rtl/lms_da_filter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lms_da_filter_pkg.sv
// Shared definitions for the LMS distributed-arithmetic filter: default sizes,
// controller states and the output-width saturation helper.
package lms_pkg;

    localparam int LMS_N_TAPS = 4;
    localparam int LMS_XW     = 8;
    localparam int LMS_WW     = 32;
    localparam int LMS_MU_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILT,
        ST_ERR,
        ST_UPD,
        ST_WR
    } lms_state_t;

    // Clamp a wide signed value into the signed range of a ww-bit integer.
    function automatic logic signed [63:0] sat_ww(input logic signed [63:0] v, input int ww);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ww - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/lms_da_mac.sv
// Bit-serial signed shift-accumulate: LSB-first steps halve the running sum,
// the sign-bit step subtracts the addend without shifting.
module lms_da_mac #(
    parameter int AW       = 35,
    parameter bit OUT_NEXT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_start,
    input  logic                 i_bit,
    input  logic                 i_msb,
    input  logic signed [AW-1:0] i_addend,
    output logic signed [AW-1:0] o_acc
);

    logic signed [AW-1:0] r_acc;
    logic signed [AW:0]   w_base;
    logic signed [AW:0]   w_add;
    logic signed [AW:0]   w_sum;
    logic signed [AW-1:0] w_next;

    always_comb begin
        w_base = i_start ? '0 : (AW+1)'(r_acc);
        w_add  = i_bit ? (AW+1)'(i_addend) : '0;
        w_sum  = i_msb ? (w_base - w_add) : (w_base + w_add);
        // One guard bit keeps the pre-shift sum exact; dropping its LSB is the arithmetic halving.
        w_next = i_msb ? w_sum[AW-1:0] : w_sum[AW:1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_next;
        end
    end

    // The filter stage needs the final sum in the same cycle as its last bit.
    assign o_acc = OUT_NEXT ? w_next : r_acc;

endmodule

// File: rtl/lms_da_filter.sv
// Adaptive LMS FIR filter: bit-serial DA filtering, error scaling by mu and a
// parallel per-tap weight update, sequenced by a five-state controller.
module lms_da_filter
    import lms_pkg::*;
#(
    parameter int N_TAPS = LMS_N_TAPS,
    parameter int XW     = LMS_XW,
    parameter int WW     = LMS_WW,
    parameter int MU_W   = LMS_MU_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [XW-1:0]               x_in,
    input  logic [WW-1:0]               d_in,
    input  logic                        x_valid,
    output logic                        x_ready,
    input  logic [MU_W-1:0]             mu,
    input  logic                        adapt_en,
    input  logic                        w_load,
    input  logic [$clog2(N_TAPS)-1:0]   w_idx,
    input  logic [WW-1:0]               w_data,
    input  logic [$clog2(N_TAPS)-1:0]   w_rd_idx,
    output logic [WW-1:0]               w_rd_data,
    output logic [WW-1:0]               y,
    output logic [WW-1:0]               e,
    output logic                        y_valid,
    output logic                        sat
);

    localparam int CW  = $clog2((XW > MU_W) ? XW : MU_W);
    localparam int BW  = $clog2(XW);
    localparam int MBW = $clog2(MU_W);
    localparam int FAW = WW + $clog2(N_TAPS) + 1;
    localparam int EAW = WW + 1;
    localparam int UAW = WW + 2;

    lms_state_t          r_state;
    logic [CW-1:0]       r_cnt;
    logic [XW-1:0]       r_taps [N_TAPS];
    logic signed [WW-1:0] r_w   [N_TAPS];
    logic signed [WW-1:0] r_d;
    logic [MU_W-1:0]     r_mu;
    logic                r_adapt;
    logic signed [WW-1:0] r_y;
    logic signed [WW-1:0] r_e;
    logic                r_y_valid;
    logic                r_sat;

    logic                 w_x_ready;
    logic                 w_start;
    logic                 w_last_bit;
    logic [N_TAPS-1:0]    w_tap_bit;
    logic [N_TAPS-1:0]    w_wclip;
    logic signed [FAW-1:0] w_filt_add;
    logic signed [FAW-1:0] w_filt_next;
    logic signed [EAW-1:0] w_me;
    logic signed [UAW-1:0] w_delta [N_TAPS];
    logic signed [63:0]   w_wsum  [N_TAPS];
    logic signed [63:0]   w_wsat  [N_TAPS];
    logic signed [63:0]   w_y_full;
    logic signed [63:0]   w_y_sat;
    logic signed [63:0]   w_e_full;
    logic signed [63:0]   w_e_sat;

    assign w_x_ready  = (r_state == ST_IDLE) && !rst && !w_load;
    assign w_start    = (r_cnt == '0);
    assign w_last_bit = (r_cnt == CW'(XW - 1));

    always_comb begin
        w_filt_add = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            if (w_tap_bit[k]) begin
                w_filt_add = w_filt_add + FAW'(r_w[k]);
            end
        end
    end

    lms_da_mac #(.AW(FAW), .OUT_NEXT(1'b1)) u_filt (
        .clk      (clk),
        .rst      (rst),
        .i_en     (r_state == ST_FILT),
        .i_start  (w_start),
        .i_bit    (1'b1),
        .i_msb    (w_last_bit),
        .i_addend (w_filt_add),
        .o_acc    (w_filt_next)
    );

    // mu is a pure fraction, so every bit (including the top one) is a halving step.
    lms_da_mac #(.AW(EAW), .OUT_NEXT(1'b0)) u_err (
        .clk      (clk),
        .rst      (rst),
        .i_en     (r_state == ST_ERR),
        .i_start  (w_start),
        .i_bit    (r_mu[r_cnt[MBW-1:0]]),
        .i_msb    (1'b0),
        .i_addend (EAW'(r_e)),
        .o_acc    (w_me)
    );

    assign w_y_full = 64'(w_filt_next);
    assign w_y_sat  = sat_ww(w_y_full, WW);
    assign w_e_full = 64'(r_d) - w_y_sat;
    assign w_e_sat  = sat_ww(w_e_full, WW);

    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
        assign w_tap_bit[gi] = r_taps[gi][r_cnt[BW-1:0]];

        lms_da_mac #(.AW(UAW), .OUT_NEXT(1'b0)) u_upd (
            .clk      (clk),
            .rst      (rst),
            .i_en     (r_state == ST_UPD),
            .i_start  (w_start),
            .i_bit    (w_tap_bit[gi]),
            .i_msb    (w_last_bit),
            .i_addend (UAW'(w_me)),
            .o_acc    (w_delta[gi])
        );

        assign w_wsum[gi]  = 64'(r_w[gi]) + 64'(w_delta[gi]);
        assign w_wsat[gi]  = sat_ww(w_wsum[gi], WW);
        assign w_wclip[gi] = (w_wsat[gi] != w_wsum[gi]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_d       <= '0;
            r_mu      <= '0;
            r_adapt   <= 1'b0;
            r_y       <= '0;
            r_e       <= '0;
            r_y_valid <= 1'b0;
            r_sat     <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) begin
                r_taps[k] <= '0;
                r_w[k]    <= '0;
            end
        end else begin
            r_y_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_w[w_idx] <= w_data;
                    end else if (x_valid) begin
                        r_taps[0] <= x_in;
                        for (int k = 1; k < N_TAPS; k++) begin
                            r_taps[k] <= r_taps[k-1];
                        end
                        r_d     <= d_in;
                        r_mu    <= mu;
                        r_adapt <= adapt_en;
                        r_cnt   <= '0;
                        r_state <= ST_FILT;
                    end
                end
                ST_FILT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last_bit) begin
                        r_y       <= w_y_sat[WW-1:0];
                        r_e       <= w_e_sat[WW-1:0];
                        r_y_valid <= 1'b1;
                        r_sat     <= r_sat | (w_y_sat != w_y_full) | (w_e_sat != w_e_full);
                        r_cnt     <= '0;
                        r_state   <= r_adapt ? ST_ERR : ST_IDLE;
                    end
                end
                ST_ERR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(MU_W - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_UPD;
                    end
                end
                ST_UPD: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last_bit) begin
                        r_cnt   <= '0;
                        r_state <= ST_WR;
                    end
                end
                ST_WR: begin
                    for (int k = 0; k < N_TAPS; k++) begin
                        r_w[k] <= w_wsat[k][WW-1:0];
                    end
                    r_sat   <= r_sat | (|w_wclip);
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign x_ready   = w_x_ready;
    assign w_rd_data = r_w[w_rd_idx];
    assign y         = r_y;
    assign e         = r_e;
    assign y_valid   = r_y_valid;
    assign sat       = r_sat;

endmodule
